mppt_po_controller: RTL and testbench

Perturb-and-observe maximum-power-point controller for the renewable-energy converter datapath. It schedules the shared 8-bit ADC sample path, first as voltage and then as current, and multiplies the two into a power figure. It compares that figure with the previous iteration and steps the converter PWM duty toward higher power. It sits between the `ui_in` sample source and the converter gate-drive output inside `tt_um_vedm_industries`.

---
 rtl/mppt_po_controller.sv | 173 +++++++++++++++++
 tb/tb_mppt_po_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mppt_po_controller.sv
// Perturb-and-observe MPPT: samples V then I on a shared ADC path, compares V*I with the
// previous iteration and steps the PWM duty toward higher power, clamped to [DUTY_MIN, DUTY_MAX].
module mppt_po_controller #(
  parameter logic [7:0] DUTY_INIT      = 8'd128,
  parameter logic [7:0] DUTY_MIN       = 8'd16,
  parameter logic [7:0] DUTY_MAX       = 8'd240,
  parameter logic [7:0] STEP           = 8'd4,
  parameter int         SETTLE_CYCLES  = 16,
  parameter int         TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [7:0]  sample_in,
  input  logic        sample_valid,
  output logic        sample_req,
  output logic        ch_sel,
  output logic [7:0]  duty,
  output logic        pwm_out,
  output logic [15:0] power_out,
  output logic        dir_up,
  output logic        sample_err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SETTLE   = 3'd1;
  localparam logic [2:0] S_SAMPLE_V = 3'd2;
  localparam logic [2:0] S_SAMPLE_I = 3'd3;
  localparam logic [2:0] S_EVAL     = 3'd4;
  localparam logic [2:0] S_UPDATE   = 3'd5;

  localparam logic [7:0] SETTLE_LOAD  = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  settle_cnt_q, settle_cnt_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]  v_q, v_d;
  logic [7:0]  i_q, i_d;
  logic [15:0] p_prev_q, p_prev_d;
  logic [15:0] power_q, power_d;
  logic        dir_q, dir_d;
  logic [7:0]  duty_q, duty_d;
  logic        err_q, err_d;
  logic [7:0]  duty_act_q;
  logic [7:0]  pwm_cnt_q;
  logic        pwm_q;

  logic [15:0]       prod;
  logic signed [9:0] duty_sum;

  assign prod     = {8'd0, v_q} * {8'd0, i_q};
  // Signed 10-bit sum so a step below zero cannot wrap past the lower clamp.
  assign duty_sum = dir_q ? ($signed({2'b00, duty_q}) + $signed({2'b00, STEP}))
                          : ($signed({2'b00, duty_q}) - $signed({2'b00, STEP}));

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    v_d          = v_q;
    i_d          = i_q;
    p_prev_d     = p_prev_q;
    power_d      = power_q;
    dir_d        = dir_q;
    duty_d       = duty_q;
    err_d        = 1'b0;
    if (!ena) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d      = S_SETTLE;
          settle_cnt_d = SETTLE_LOAD;
        end
        S_SETTLE: begin
          if (settle_cnt_q == 8'd0) begin
            state_d    = S_SAMPLE_V;
            wait_cnt_d = 8'd0;
          end else begin
            settle_cnt_d = settle_cnt_q - 8'd1;
          end
        end
        S_SAMPLE_V, S_SAMPLE_I: begin
          if (sample_valid) begin
            wait_cnt_d = 8'd0;
            if (state_q == S_SAMPLE_V) begin
              v_d     = sample_in;
              state_d = S_SAMPLE_I;
            end else begin
              i_d     = sample_in;
              state_d = S_EVAL;
            end
          end else if (wait_cnt_q == TIMEOUT_LAST) begin
            err_d        = 1'b1;
            state_d      = S_SETTLE;
            settle_cnt_d = SETTLE_LOAD;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
        S_EVAL: begin
          if (prod < p_prev_q) dir_d = ~dir_q;
          power_d  = prod;
          p_prev_d = prod;
          state_d  = S_UPDATE;
        end
        S_UPDATE: begin
          if (duty_sum < $signed({2'b00, DUTY_MIN})) begin
            duty_d = DUTY_MIN;
            dir_d  = 1'b1;
          end else if (duty_sum > $signed({2'b00, DUTY_MAX})) begin
            duty_d = DUTY_MAX;
            dir_d  = 1'b0;
          end else begin
            duty_d = duty_sum[7:0];
          end
          settle_cnt_d = SETTLE_LOAD;
          state_d      = S_SETTLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      settle_cnt_q <= 8'd0;
      wait_cnt_q   <= 8'd0;
      v_q          <= 8'd0;
      i_q          <= 8'd0;
      p_prev_q     <= 16'd0;
      power_q      <= 16'd0;
      dir_q        <= 1'b1;
      duty_q       <= DUTY_INIT;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      v_q          <= v_d;
      i_q          <= i_d;
      p_prev_q     <= p_prev_d;
      power_q      <= power_d;
      dir_q        <= dir_d;
      duty_q       <= duty_d;
      err_q        <= err_d;
    end
  end

  // Gate drive is registered so it is low in reset; duty is only adopted at the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q  <= 8'd0;
      duty_act_q <= DUTY_INIT;
      pwm_q      <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
      if (pwm_cnt_q == 8'hFF) duty_act_q <= duty_q;
      pwm_q <= ena & (pwm_cnt_q < duty_act_q);
    end
  end

  assign sample_req = (state_q == S_SAMPLE_V) || (state_q == S_SAMPLE_I);
  assign ch_sel     = (state_q == S_SAMPLE_I);
  assign duty       = duty_q;
  assign pwm_out    = pwm_q;
  assign power_out  = power_q;
  assign dir_up     = dir_q;
  assign sample_err = err_q;

endmodule

// File: tb/tb_mppt_po_controller.sv
// Directed bench for mppt_po_controller: P&O stepping, clamping, timeout, enable drop and reset.
module tb_mppt_po_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [7:0]  sample_in;
  logic        sample_valid;
  logic        sample_req;
  logic        ch_sel;
  logic [7:0]  duty;
  logic        pwm_out;
  logic [15:0] power_out;
  logic        dir_up;
  logic        sample_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mppt_po_controller dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sample_in(sample_in),
    .sample_valid(sample_valid), .sample_req(sample_req), .ch_sel(ch_sel),
    .duty(duty), .pwm_out(pwm_out), .power_out(power_out), .dir_up(dir_up),
    .sample_err(sample_err)
  );

  task automatic wait_v_req(input string tag);
    int n = 0;
    while (!(sample_req === 1'b1 && ch_sel === 1'b0) && n < 600) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!(sample_req === 1'b1 && ch_sel === 1'b0)) begin
      bad++;
      $display("FAIL %s v_req: no voltage request within %0d cycles", tag, n);
    end
  endtask

  // One full iteration with back-to-back valids; checks power/dir after EVAL and duty/dir after UPDATE.
  task automatic do_iter(input logic [7:0] v, input logic [7:0] i, input logic [15:0] ep,
                         input logic edir_eval, input logic [7:0] eduty, input logic edir_fin,
                         input string tag);
    wait_v_req(tag);
    sample_valid = 1'b1;
    sample_in    = v;
    @(negedge clk);
    total++;
    if (ch_sel !== 1'b1 || sample_req !== 1'b1) begin
      bad++;
      $display("FAIL %s ch_sel: got ch_sel=%b req=%b want 1/1", tag, ch_sel, sample_req);
    end
    sample_in = i;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    total++;
    if (power_out !== ep || dir_up !== edir_eval) begin
      bad++;
      $display("FAIL %s eval: got power=%0d dir=%b want power=%0d dir=%b",
               tag, power_out, dir_up, ep, edir_eval);
    end
    @(negedge clk);
    total++;
    if (duty !== eduty || dir_up !== edir_fin || sample_req !== 1'b0) begin
      bad++;
      $display("FAIL %s update: got duty=%0d dir=%b req=%b want duty=%0d dir=%b req=0",
               tag, duty, dir_up, sample_req, eduty, edir_fin);
    end
  endtask

  task automatic count_to_req(output int n);
    n = 0;
    while (sample_req !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ena = 1'b0; sample_valid = 1'b0; sample_in = 8'd0;
    repeat (3) @(negedge clk);
    total++;
    if (duty !== 8'd128 || dir_up !== 1'b1 || power_out !== 16'd0 || sample_req !== 1'b0 ||
        ch_sel !== 1'b0 || pwm_out !== 1'b0 || sample_err !== 1'b0) begin
      bad++;
      $display("FAIL reset: got duty=%0d dir=%b pwr=%0d req=%b ch=%b pwm=%b err=%b want 128/1/0/0/0/0/0",
               duty, dir_up, power_out, sample_req, ch_sel, pwm_out, sample_err);
    end
  endtask

  task automatic test_first_request;
    int n;
    ena   = 1'b1;
    rst_n = 1'b1;
    count_to_req(n);
    total++;
    if (n != 17) begin
      bad++;
      $display("FAIL first_req: got %0d cycles want 17", n);
    end
  endtask

  task automatic test_pwm_duty;
    int hi = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (pwm_out === 1'b1) hi++;
    end
    total++;
    if (hi != 128 || duty !== 8'd128) begin
      bad++;
      $display("FAIL pwm_duty: got high=%0d duty=%0d want 128/128", hi, duty);
    end
  endtask

  task automatic test_po_steps;
    do_iter(8'd100, 8'd50, 16'd5000, 1'b1, 8'd132, 1'b1, "step1");
    do_iter(8'd100, 8'd60, 16'd6000, 1'b1, 8'd136, 1'b1, "step2");
    do_iter(8'd100, 8'd40, 16'd4000, 1'b0, 8'd132, 1'b0, "step3_reverse");
  endtask

  task automatic test_clamp_max;
    int  ed;
    logic efin;
    do_iter(8'd100, 8'd39, 16'd3900, 1'b1, 8'd136, 1'b1, "flip_up");
    ed = 136;
    for (int k = 0; k < 27; k++) begin
      ed   = ed + 4;
      efin = 1'b1;
      if (ed > 240) begin
        ed   = 240;
        efin = 1'b0;
      end
      do_iter(8'd100, 8'(40 + k), 16'(100 * (40 + k)), 1'b1, 8'(ed), efin, "climb");
    end
    total++;
    if (duty !== 8'd240 || dir_up !== 1'b0) begin
      bad++;
      $display("FAIL clamp_max: got duty=%0d dir=%b want 240/0", duty, dir_up);
    end
  endtask

  task automatic test_timeout;
    int t = 0;
    int n;
    wait_v_req("timeout");
    sample_valid = 1'b1;
    sample_in    = 8'd100;
    @(negedge clk);
    sample_valid = 1'b0;
    while (sample_err !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (t != 255) begin
      bad++;
      $display("FAIL timeout_len: got err after %0d cycles want 255", t);
    end
    total++;
    if (duty !== 8'd240 || power_out !== 16'd6600 || sample_req !== 1'b0) begin
      bad++;
      $display("FAIL timeout_hold: got duty=%0d pwr=%0d req=%b want 240/6600/0",
               duty, power_out, sample_req);
    end
    @(negedge clk);
    total++;
    if (sample_err !== 1'b0) begin
      bad++;
      $display("FAIL timeout_pulse: got err=%b a cycle later want 0", sample_err);
    end
    count_to_req(n);
    total++;
    if (n != 15) begin
      bad++;
      $display("FAIL timeout_resettle: got req %0d cycles after pulse+1 want 15", n);
    end
    // 6500 < retained 6600 flips dir up, then the max clamp pushes it back down.
    do_iter(8'd100, 8'd65, 16'd6500, 1'b1, 8'd240, 1'b0, "after_timeout");
  endtask

  task automatic test_ena_drop;
    int n;
    wait_v_req("ena_drop");
    ena          = 1'b0;
    sample_valid = 1'b1;
    sample_in    = 8'd200;
    @(negedge clk);
    total++;
    if (sample_req !== 1'b0 || pwm_out !== 1'b0 || duty !== 8'd240) begin
      bad++;
      $display("FAIL ena_drop: got req=%b pwm=%b duty=%0d want 0/0/240", sample_req, pwm_out, duty);
    end
    repeat (3) @(negedge clk);
    sample_valid = 1'b0;
    total++;
    if (power_out !== 16'd6500 || pwm_out !== 1'b0 || dir_up !== 1'b0) begin
      bad++;
      $display("FAIL ena_hold: got pwr=%0d pwm=%b dir=%b want 6500/0/0", power_out, pwm_out, dir_up);
    end
    ena = 1'b1;
    count_to_req(n);
    total++;
    if (n != 17) begin
      bad++;
      $display("FAIL reenable: got req after %0d cycles want 17", n);
    end
    do_iter(8'd100, 8'd66, 16'd6600, 1'b0, 8'd236, 1'b0, "after_reenable");
  endtask

  task automatic test_reset_mid;
    wait_v_req("reset_mid");
    sample_valid = 1'b1;
    sample_in    = 8'd77;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (duty !== 8'd128 || dir_up !== 1'b1 || power_out !== 16'd0 ||
        sample_req !== 1'b0 || ch_sel !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: got duty=%0d dir=%b pwr=%0d req=%b ch=%b want 128/1/0/0/0",
               duty, dir_up, power_out, sample_req, ch_sel);
    end
    sample_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_request();
    test_pwm_duty();
    test_po_steps();
    test_clamp_max();
    test_timeout();
    test_ena_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
